pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the 5-stage RISC-V core. It replaces the plain always-load stage registers between IF/ID/EX/MEM/WB.
- Adds a valid/ready handshake, a synchronous active-low reset, a flush that inserts a bubble, and an optional 1-entry skid buffer. The skid buffer lets `in_ready` come from a flop instead of a combinational path through `out_ready`.
- One instance per stage boundary; `WIDTH` is sized to the bundled stage payload.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- BUBBLE, 32'h00000013, value driven on `out_data` when empty or after a flush/reset (RV32I NOP `addi x0,x0,0`). Zero-extended or truncated to `WIDTH`.
- SKID, 1, 1 = registered `in_ready` with 1-entry skid buffer; 0 = single register, combinational `in_ready`.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST_N  input  1  synchronous active-low reset.
- flush  input  1  discard all held and incoming data this cycle.
- in_valid  input  1  upstream presents `in_data`.
- in_ready  output  1  stage can accept; a transfer occurs when `in_valid && in_ready` at the edge.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  `out_data` holds a valid item.
- out_ready  input  1  downstream accepts; a transfer occurs when `out_valid && out_ready` at the edge.
- out_data  output  WIDTH  payload to the next stage.

Behaviour:
- Reset (RST_N=0 at an edge):
  - `out_valid`=0, `out_data`=BUBBLE, skid empty.
  - `in_ready`=1 after the reset edge.
  - Handshakes in the reset cycle are ignored.
- Priority: reset > flush > normal operation.
- Flush (RST_N=1, flush=1 at an edge):
  - Main and skid valid bits cleared; `out_data`=BUBBLE.
  - A coincident input transfer is dropped.
  - A coincident output transfer still counts as completed downstream; the stage is empty afterwards.
- Latency and throughput: an item accepted at edge N appears on `out_valid`/`out_data` after edge N. Sustained throughput is 1 item/cycle when `out_ready`=1.
- Stability: while `out_valid && !out_ready`, `out_data` and `out_valid` hold unchanged.
- SKID=0:
  - `in_ready = !out_valid || out_ready` (combinational).
  - The main register loads `in_data` on an input transfer.
  - `out_valid` clears on an output transfer with no input transfer.
- SKID=1, state is {main_valid, skid_valid}:
  - `in_ready = !skid_valid`, purely registered. `out_valid = main_valid`.
  - EMPTY (0,0): input transfer → MAIN (1,0).
  - MAIN (1,0):
    - out & in transfer → MAIN (main ← in).
    - out only → EMPTY.
    - in only (out stalled) → FULL (1,1), skid ← in.
  - FULL (1,1): `in_ready`=0, so no input is accepted. Output transfer → main ← skid → MAIN.
  - (0,1) is unreachable; treat it as an assertion failure.
- Ordering: items leave in acceptance order; no item is duplicated or lost except by flush/reset.
- Empty output: when `out_valid`=0, `out_data` shows BUBBLE. Its value is otherwise not relied on but is fixed for verification.
- Reset mid-stall: all held items are discarded, identical to the reset case.

Test Plan:
- Reset, SKID=1: hold RST_N=0 for 2 cycles with in_valid=1, in_data=0xDEADBEEF → after release `out_valid`=0, `out_data`=0x00000013, `in_ready`=1.
- Streaming, SKID=1: send 0x1..0x8 back-to-back with out_ready=1 → outputs 0x1..0x8 on 8 consecutive cycles, 1-cycle latency, `in_ready` never drops.
- Skid fill: send 0xA, 0xB, 0xC with in_valid held and out_ready=0 from the first output cycle → `out_data`=0xA held, 0xB in skid, `in_ready`=0, 0xC not accepted. Then out_ready=1 → outputs 0xA, 0xB, 0xC in order, none lost.
- Flush: FULL state (0xA main, 0xB skid), assert flush with in_valid=1, in_data=0xC → next cycle `out_valid`=0, `out_data`=0x13, `in_ready`=1, and 0xC never appears.
- SKID=0, WIDTH=64: random in_valid/out_ready at 50% for 1000 items → scoreboard matches in order; `in_ready` equals `!out_valid || out_ready` every cycle.
- Reset mid-stall: MAIN state with out_ready=0, assert RST_N=0 for one edge → `out_valid`=0 next cycle and the held item is never delivered.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, bubble-on-flush and an
// optional 1-entry skid buffer that breaks the in_ready <- out_ready path.
module pipe_stage_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [31:0] BUBBLE = 32'h00000013,
  parameter int unsigned SKID   = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             in_fire;
  logic             out_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  assign out_valid = main_valid;
  // Empty stage always presents the NOP so downstream sees a clean bubble.
  assign out_data  = main_valid ? main_data : BUBBLE_W;

  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'b00,
      MAIN  = 2'b10,
      FULL  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;

    assign main_valid = state[1];
    assign in_ready   = !state[0];

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        state     <= EMPTY;
        main_data <= BUBBLE_W;
        skid_data <= BUBBLE_W;
      end else if (flush) begin
        state     <= EMPTY;
        main_data <= BUBBLE_W;
        skid_data <= BUBBLE_W;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state     <= MAIN;
              main_data <= in_data;
            end
          end
          MAIN: begin
            if (in_fire && out_fire) begin
              main_data <= in_data;
            end else if (out_fire) begin
              state <= EMPTY;
            end else if (in_fire) begin
              state     <= FULL;
              skid_data <= in_data;
            end
          end
          FULL: begin
            if (out_fire) begin
              state     <= MAIN;
              main_data <= skid_data;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end

    a_no_skid_without_main: assert property (
      @(posedge CLK) disable iff (!RST_N) !(state[0] && !state[1]));
  end else begin : g_noskid
    logic valid_q;

    assign main_valid = valid_q;
    assign in_ready   = !valid_q || out_ready;

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        valid_q   <= 1'b0;
        main_data <= BUBBLE_W;
      end else if (flush) begin
        valid_q   <= 1'b0;
        main_data <= BUBBLE_W;
      end else if (in_fire) begin
        valid_q   <= 1'b1;
        main_data <= in_data;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1/WIDTH=32 instance for handshake,
// skid, flush and reset cases; SKID=0/WIDTH=64 instance for a random stream.
module tb_pipe_stage_reg;

  logic        CLK;
  logic        RST_N;
  logic        flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [63:0] in_data0, out_data0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pipe_stage_reg #(.WIDTH(32), .BUBBLE(32'h00000013), .SKID(1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  pipe_stage_reg #(.WIDTH(64), .BUBBLE(32'h00000013), .SKID(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] q[$];
    logic [63:0] exp_item;
    logic        fire_in, fire_out;
    int unsigned sent, rcvd, cyc;

    RST_N = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;

    // Reset held two cycles with a live input
    repeat (2) tick();
    RST_N = 1'b1; in_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 32'h13);
    check("rst_in_ready", in_ready, 1);
    check("rst0_out_valid", out_valid0, 0);
    check("rst0_out_data", out_data0, 64'h13);

    // Back-to-back streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      #1 check("stream_in_ready", in_ready, 1);
      @(posedge CLK); #1;
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data", out_data, i);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_data", out_data, 32'h13);

    // Skid fill: A in main, B in skid, C held off
    in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 32'hB;
    tick();
    check("skid_main_a", out_data, 32'hA);
    check("skid_in_ready_lo", in_ready, 0);
    in_data = 32'hC;
    tick();
    check("skid_hold_valid", out_valid, 1);
    check("skid_hold_data", out_data, 32'hA);
    check("skid_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("skid_out_b", out_data, 32'hB);
    check("skid_in_ready_hi", in_ready, 1);
    tick();
    check("skid_out_c", out_data, 32'hC);
    in_valid = 1'b0;
    tick();
    check("skid_empty", out_valid, 0);

    // Flush from FULL with a coincident input
    in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
    tick();
    in_data = 32'hB;
    tick();
    check("flush_pre_ready", in_ready, 0);
    flush = 1'b1; in_data = 32'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 32'h13);
    check("flush_in_ready", in_ready, 1);
    repeat (3) begin
      tick();
      check("flush_no_c", out_valid, 0);
    end

    // Reset while an item is stalled in main
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("midrst_held", out_valid, 1);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 32'h13);
    out_ready = 1'b1;
    repeat (2) begin
      tick();
      check("midrst_lost", out_valid, 0);
    end

    // SKID=0, WIDTH=64: random handshakes against an in-order scoreboard
    sent = 0; rcvd = 0; cyc = 0;
    in_data0 = {$urandom, $urandom};
    while (rcvd < 1000 && cyc < 20000) begin
      in_valid0  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      out_ready0 = ($urandom_range(0, 1) == 1);
      #1;
      check("s0_in_ready", in_ready0, !out_valid0 || out_ready0);
      check("s0_out_valid", out_valid0, q.size() != 0);
      fire_in  = in_valid0 && in_ready0;
      fire_out = out_valid0 && out_ready0;
      if (fire_out) begin
        exp_item = (q.size() != 0) ? q.pop_front() : 64'h13;
        check("s0_out_data", out_data0, exp_item);
        rcvd++;
      end
      if (fire_in) begin
        q.push_back(in_data0);
        sent++;
      end
      @(posedge CLK); #1;
      if (fire_in) in_data0 = {$urandom, $urandom};
      cyc++;
    end
    in_valid0 = 1'b0;
    check("s0_all_received", rcvd, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
